downscale_ctrl: RTL and testbench
=================================

Name: downscale_ctrl

Overview:
- Sequencer for the softmax downscale stage (downscale_block_16): on start_i it reads number_of_data FP32 words from the input buffer and issues them to the downscale block at a programmable spacing.
- It collects the FP16 results in arrival order and writes them to the output buffer.
- It raises done_o once all results are stored, with timeout and protocol-error detection.
- Sits between the FP32 score buffer and the FP16 exponent/normalisation stages.

Parameters:
data_size, 16, FP16 output width; FP32 input width is 2*data_size
number_of_data, 10, words per job (>=1)
addr_width, 4, buffer address width; must satisfy 2**addr_width >= number_of_data
issue_gap, 2, cycles between successive issues (>=1)
timeout, 64, max idle cycles waiting for a result in DRAIN

Ports:
clock_i  in  1  clock; all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  job start pulse; honoured in IDLE only
busy_o  out  1  high from the cycle after accepted start until return to IDLE
done_o  out  1  one-cycle pulse at job end
error_o  out  1  sticky error flag; cleared on reset or accepted start
rd_en_o  out  1  input-buffer read strobe
rd_addr_o  out  addr_width  input-buffer read address
rd_data_i  in  2*data_size  read data, valid exactly 1 cycle after rd_en_o
ds_valid_o  out  1  to downscale_data_valid_i
ds_data_o  out  2*data_size  to downscale_data_i
ds_valid_i  in  1  from downscale_data_valid_o
ds_data_i  in  data_size  from downscale_data_o
wr_en_o  out  1  output-buffer write strobe
wr_addr_o  out  addr_width  output-buffer write address
wr_data_o  out  data_size  output-buffer write data

Behaviour:
- Reset: every output 0; all counters 0; state IDLE. Reset asserted mid-job aborts the job immediately; no done_o pulse follows.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_i=1: clear error_o and counters, then go to ISSUE.
  - ds_valid_i=1: set error_o; the result is not written.
- ISSUE:
  - rd_en_o high on the first ISSUE cycle, then every issue_gap cycles.
  - rd_addr_o = issue count (0..number_of_data-1).
  - After the read with address number_of_data-1, go to DRAIN.
  - issue_gap=1 gives back-to-back reads.
- Issue path:
  - ds_valid_o is rd_en_o delayed by 1 register.
  - ds_data_o = rd_data_i, passed combinationally while ds_valid_o=1; 0 otherwise.
- Collect path, active in ISSUE and DRAIN:
  - Each ds_valid_i=1 produces wr_en_o=1 in the next cycle, with wr_data_o = registered ds_data_i and wr_addr_o = collected count.
  - The collected count then increments.
- Ordering: results are assumed in issue order; the block makes no latency assumption.
- Extra results: a ds_valid_i after number_of_data results have been collected sets error_o and is not written.
- DRAIN:
  - Collected count reaches number_of_data (the cycle the last wr_en_o is high): go to DONE.
  - Timeout counter resets on each ds_valid_i. If it reaches timeout first: set error_o and go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. start_i in DONE is ignored.
- start_i while busy: ignored, with no effect on counters.
- Collection during ISSUE: results arriving while still issuing are collected normally. If the last result arrives in the same cycle as the final issue, DRAIN lasts exactly one cycle.
- Counter widths: issue and collect counters are addr_width+1 bits, so there is no wrap at 2**addr_width; the timeout counter is clog2(timeout+1) bits.
- Latency, start to first rd_en_o: 1 cycle.
- Latency, last result to done_o: 2 cycles (write cycle, then DONE).

Test Plan:
1. Normal job:
   - Stimulus: bench model of the downscale block, 3-cycle latency; buffer word 0 = 0xC05060D2, word 1 = 0x40A5D0A4; issue_gap=2.
   - Response: rd_en_o at start+1, +3, +5, ...; wr_data_o[0]=0xC283 at addr 0, word 1 = 0x452F at addr 1; 10 writes; done_o 2 cycles after the 10th ds_valid_i; error_o=0.
2. issue_gap=1, latency 1:
   - Response: 10 consecutive rd_en_o cycles, 10 consecutive wr_en_o cycles, addresses 0..9 in order, single done_o pulse.
3. Stall:
   - Stimulus: model withholds result 7.
   - Response: after 64 idle cycles in DRAIN, error_o=1 and done_o pulses; only 7 writes (addresses 0..6).
4. Spurious and extra results:
   - ds_valid_i in IDLE: error_o=1, no wr_en_o. A following start_i clears error_o.
   - 11th ds_valid_i after the job completes: error_o=1, no write.
5. Start while busy:
   - Stimulus: start_i pulsed at issue 4 and in the DONE cycle.
   - Response: both pulses ignored; exactly 10 reads per job.
6. Reset mid-job:
   - Stimulus: reset_i asserted after 5 issues, asynchronously between clock edges.
   - Response: all outputs 0 immediately, no done_o. A new start_i restarts at rd_addr_o=0 and wr_addr_o=0.

Source files
------------

// File: rtl/downscale_ctrl.sv
// Sequencer for the softmax downscale stage: reads FP32 words from the score
// buffer, issues them to the downscale block at a fixed spacing, and stores
// the FP16 results in the output buffer in arrival order.
module downscale_ctrl #(
    parameter int data_size      = 16,
    parameter int number_of_data = 10,
    parameter int addr_width     = 4,
    parameter int issue_gap      = 2,
    parameter int timeout        = 64
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic                     rd_en_o,
    output logic [addr_width-1:0]    rd_addr_o,
    input  logic [2*data_size-1:0]   rd_data_i,
    output logic                     ds_valid_o,
    output logic [2*data_size-1:0]   ds_data_o,
    input  logic                     ds_valid_i,
    input  logic [data_size-1:0]     ds_data_i,
    output logic                     wr_en_o,
    output logic [addr_width-1:0]    wr_addr_o,
    output logic [data_size-1:0]     wr_data_o
);

    localparam int cnt_w = addr_width + 1;
    localparam int gap_w = $clog2(issue_gap + 1);
    localparam int tmo_w = $clog2(timeout + 1);

    localparam logic [cnt_w-1:0] last_idx   = cnt_w'(number_of_data - 1);
    localparam logic [cnt_w-1:0] n_total    = cnt_w'(number_of_data);
    localparam logic [gap_w-1:0] gap_reload = gap_w'(issue_gap - 1);
    localparam logic [tmo_w-1:0] tmo_max    = tmo_w'(timeout);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [cnt_w-1:0]   issue_cnt, coll_cnt;
    logic [gap_w-1:0]   gap_cnt;
    logic [tmo_w-1:0]   tmo_cnt;
    logic               start_ok, accept, timed_out;

    // Next-state decode plus the state-derived outputs.
    always_comb begin
        state_nx  = state;
        busy_o    = (state != IDLE);
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        case (state)
            IDLE: begin
                if (start_i) state_nx = ISSUE;
            end
            ISSUE: begin
                if (gap_cnt == '0) begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = issue_cnt[addr_width-1:0];
                    if (issue_cnt == last_idx) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (coll_cnt == n_total || tmo_cnt == tmo_max) state_nx = DONE;
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result acceptance, timeout detection and the gated issue data path.
    always_comb begin
        start_ok  = (state == IDLE) && start_i;
        accept    = ((state == ISSUE) || (state == DRAIN)) && ds_valid_i && (coll_cnt < n_total);
        timed_out = (state == DRAIN) && (tmo_cnt == tmo_max) && (coll_cnt != n_total);
        ds_data_o = ds_valid_o ? rd_data_i : '0;
    end

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    // Issue, collect, spacing and idle-timeout counters; cleared on accepted start.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            issue_cnt <= '0;
            coll_cnt  <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else if (start_ok) begin
            issue_cnt <= '0;
            coll_cnt  <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (rd_en_o) begin
                issue_cnt <= issue_cnt + cnt_w'(1);
                gap_cnt   <= gap_reload;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - gap_w'(1);
            end
            if (accept) coll_cnt <= coll_cnt + cnt_w'(1);
            if (state == DRAIN) begin
                if (ds_valid_i)              tmo_cnt <= '0;
                else if (tmo_cnt != tmo_max) tmo_cnt <= tmo_cnt + tmo_w'(1);
            end
        end
    end

    // Issue strobe delay, result write-back register and sticky error flag.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ds_valid_o <= 1'b0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            error_o    <= 1'b0;
        end else begin
            ds_valid_o <= rd_en_o;
            wr_en_o    <= accept;
            if (accept) begin
                wr_addr_o <= coll_cnt[addr_width-1:0];
                wr_data_o <= ds_data_i;
            end
            if ((ds_valid_i && !accept) || timed_out) error_o <= 1'b1;
            else if (start_ok)                        error_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_downscale_ctrl.sv
// Self-checking bench for downscale_ctrl: two instances (issue_gap 2 and 1)
// driven by a behavioural buffer and downscale-block model.
module tb_downscale_ctrl;

    localparam int N   = 10;
    localparam int AW  = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [2];
    logic        busy [2], done [2], err [2], rd_en [2], dsv_o [2], dsv_i [2], wr_en [2];
    logic [AW-1:0] rd_addr [2], wr_addr [2];
    logic [31:0] rd_data [2], ds_dat_o [2];
    logic [15:0] ds_dat_i [2], wr_data [2];

    downscale_ctrl #(.data_size(16), .number_of_data(N), .addr_width(AW), .issue_gap(2), .timeout(TMO)) dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .error_o(err[0]), .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
        .ds_valid_o(dsv_o[0]), .ds_data_o(ds_dat_o[0]), .ds_valid_i(dsv_i[0]), .ds_data_i(ds_dat_i[0]),
        .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]));

    downscale_ctrl #(.data_size(16), .number_of_data(N), .addr_width(AW), .issue_gap(1), .timeout(TMO)) dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .error_o(err[1]), .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
        .ds_valid_o(dsv_o[1]), .ds_data_o(ds_dat_o[1]), .ds_valid_i(dsv_i[1]), .ds_data_i(ds_dat_i[1]),
        .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]));

    int gap_of [2] = '{2, 1};

    // FP32 -> FP16 round-to-nearest-even, normal range only
    function automatic logic [15:0] to_f16(input logic [31:0] x);
        logic [4:0]  e16;
        logic [9:0]  mt;
        logic [12:0] rem;
        logic        rnd;
        e16 = 5'(x[30:23] - 8'd112);
        mt  = x[22:13];
        rem = x[12:0];
        rnd = (rem > 13'h1000) || ((rem == 13'h1000) && mt[0]);
        return {x[31], e16, mt} + {15'd0, rnd};
    endfunction

    function automatic logic [31:0] rnd_f32();
        logic [7:0] e;
        e = 8'(113 + $urandom_range(0, 27));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // ---- behavioural models: written by the stimulus process only ----
    logic [31:0] mem [2][16];
    int lat [2]      = '{3, 3};
    int withhold [2] = '{99, 99};
    int inj_req [2]  = '{0, 0};

    // ---- recorded by the monitor process only ----
    int cyc = 0;
    int inj_done [2] = '{0, 0};
    int n_rd [2]     = '{0, 0};
    int n_wr [2]     = '{0, 0};
    int n_push [2]   = '{0, 0};
    int n_pop [2]    = '{0, 0};
    int n_done [2]   = '{0, 0};
    int gate_bad [2] = '{0, 0};
    int start_cyc [2], done_cyc [2], last_dsv [2];
    int rd_cyc [2][16], rd_adr [2][16], wr_cyc [2][16], wr_adr [2][16], res_due [2][16];
    logic [15:0] wr_dat [2][16], res_dat [2][16];
    logic [31:0] ds_seen [2][16];

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous input buffer: data one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            rd_data[u] <= rd_en[u] ? mem[u][rd_addr[u]] : $urandom;
    end

    // monitor + downscale-block model: fixed latency, in-order, optional withholding
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                n_pop[u]   = n_push[u];
                dsv_i[u]   = 1'b0;
                ds_dat_i[u] = '0;
            end else begin
                if (start[u] && !busy[u]) begin
                    n_rd[u] = 0; n_wr[u] = 0; n_push[u] = 0; n_pop[u] = 0;
                    n_done[u] = 0; gate_bad[u] = 0; last_dsv[u] = -1; done_cyc[u] = -1;
                    start_cyc[u] = cyc;
                end
                if (rd_en[u]) begin
                    if (n_rd[u] < 16) begin rd_cyc[u][n_rd[u]] = cyc; rd_adr[u][n_rd[u]] = int'(rd_addr[u]); end
                    n_rd[u]++;
                end
                if (!dsv_o[u] && ds_dat_o[u] != '0) gate_bad[u]++;
                if (dsv_o[u]) begin
                    if (n_push[u] < 16) begin
                        ds_seen[u][n_push[u]] = ds_dat_o[u];
                        res_due[u][n_push[u]] = cyc + lat[u];
                        res_dat[u][n_push[u]] = to_f16(ds_dat_o[u]);
                    end
                    n_push[u]++;
                end
                if (wr_en[u]) begin
                    if (n_wr[u] < 16) begin
                        wr_cyc[u][n_wr[u]] = cyc; wr_adr[u][n_wr[u]] = int'(wr_addr[u]); wr_dat[u][n_wr[u]] = wr_data[u];
                    end
                    n_wr[u]++;
                end
                if (done[u]) begin n_done[u]++; done_cyc[u] = cyc; end
                dsv_i[u]    = 1'b0;
                ds_dat_i[u] = 16'($urandom);
                if (inj_req[u] != inj_done[u]) begin
                    inj_done[u]++;
                    dsv_i[u] = 1'b1;
                end else if (n_pop[u] < n_push[u] && n_pop[u] < 16 && res_due[u][n_pop[u]] == cyc) begin
                    if (n_pop[u] < withhold[u]) begin
                        dsv_i[u]    = 1'b1;
                        ds_dat_i[u] = res_dat[u][n_pop[u]];
                        last_dsv[u] = cyc;
                    end
                    n_pop[u]++;
                end
            end
        end
    end

    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input int u, input string tag);
        chk($sformatf("%s_outputs_zero_u%0d", tag, u),
            64'({busy[u], done[u], err[u], rd_en[u], rd_addr[u], dsv_o[u], ds_dat_o[u], wr_en[u], wr_addr[u], wr_data[u]}), 64'd0);
    endtask

    typedef struct {
        int unit; int lat; int withhold; bit poke; bit tmo; int writes; bit err;
    } job_t;

    task automatic run_job(input job_t j);
        int u, d;
        bit fin, poked;
        u = j.unit;
        lat[u] = j.lat;
        withhold[u] = j.withhold;
        mem[u][0] = 32'hC05060D2;
        mem[u][1] = 32'h40A5D0A4;
        for (int i = 2; i < 16; i++) mem[u][i] = rnd_f32();
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        chk($sformatf("busy_after_start_u%0d", u), 64'(busy[u]), 64'd1);
        chk($sformatf("err_cleared_on_start_u%0d", u), 64'(err[u]), 64'd0);
        chk($sformatf("first_rd_en_u%0d", u), 64'(rd_en[u]), 64'd1);
        fin = 1'b0; poked = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            tick();
            start[u] = 1'b0;
            if (j.poke && !poked && n_rd[u] == 5) begin start[u] = 1'b1; poked = 1'b1; end
            if (done[u]) begin fin = 1'b1; if (j.poke) start[u] = 1'b1; end
        end
        chk($sformatf("done_within_bound_u%0d", u), 64'(fin), 64'd1);
        tick();
        start[u] = 1'b0;
        repeat (2) tick();
        chk($sformatf("idle_after_job_u%0d", u), 64'(busy[u]), 64'd0);
        chk($sformatf("single_done_u%0d", u), 64'(n_done[u]), 64'd1);
        chk($sformatf("read_count_u%0d", u), 64'(n_rd[u]), 64'(N));
        chk($sformatf("start_to_rd_u%0d", u), 64'(rd_cyc[u][0] - start_cyc[u]), 64'd1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rd_addr_u%0d_%0d", u, i), 64'(rd_adr[u][i]), 64'(i));
            chk($sformatf("ds_data_u%0d_%0d", u, i), 64'(ds_seen[u][i]), 64'(mem[u][i]));
            if (i > 0) chk($sformatf("rd_gap_u%0d_%0d", u, i), 64'(rd_cyc[u][i] - rd_cyc[u][i-1]), 64'(gap_of[u]));
        end
        chk($sformatf("write_count_u%0d", u), 64'(n_wr[u]), 64'(j.writes));
        for (int i = 0; i < j.writes; i++) begin
            chk($sformatf("wr_addr_u%0d_%0d", u, i), 64'(wr_adr[u][i]), 64'(i));
            chk($sformatf("wr_data_u%0d_%0d", u, i), 64'(wr_dat[u][i]), 64'(to_f16(mem[u][i])));
            if (i > 0) chk($sformatf("wr_gap_u%0d_%0d", u, i), 64'(wr_cyc[u][i] - wr_cyc[u][i-1]), 64'(gap_of[u]));
        end
        if (j.writes >= 2) begin
            chk($sformatf("wr_word0_u%0d", u), 64'(wr_dat[u][0]), 64'h C283);
            chk($sformatf("wr_word1_u%0d", u), 64'(wr_dat[u][1]), 64'h 452F);
        end
        chk($sformatf("ds_data_gated_u%0d", u), 64'(gate_bad[u]), 64'd0);
        chk($sformatf("error_flag_u%0d", u), 64'(err[u]), 64'(j.err));
        if (!j.tmo) begin
            chk($sformatf("last_result_to_done_u%0d", u), 64'(done_cyc[u] - last_dsv[u]), 64'd2);
        end else begin
            d = done_cyc[u] - rd_cyc[u][N-1];
            chk($sformatf("timeout_window_u%0d_d%0d", u, d), 64'(d >= TMO + 1 && d <= TMO + 3), 64'd1);
        end
    endtask

    job_t jobs [7];

    initial begin
        int saved_wr, saved_done;
        bit hit;
        job_t rj;

        jobs[0] = '{0, 3, 99, 1'b0, 1'b0, 10, 1'b0};   // normal job
        jobs[1] = '{1, 1, 99, 1'b0, 1'b0, 10, 1'b0};   // back-to-back issue, latency 1
        jobs[2] = '{0, 3, 7,  1'b0, 1'b1, 7,  1'b1};   // stall from result 7
        jobs[3] = '{0, 2, 99, 1'b1, 1'b0, 10, 1'b0};   // start while busy and in DONE
        jobs[4] = '{1, 4, 99, 1'b1, 1'b0, 10, 1'b0};
        jobs[5] = '{1, 5, 3,  1'b0, 1'b1, 3,  1'b1};
        jobs[6] = '{0, 1, 99, 1'b0, 1'b0, 10, 1'b0};   // last result with the final issue

        for (int u = 0; u < 2; u++) start[u] = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #3;
        for (int u = 0; u < 2; u++) chk_zero(u, "in_reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        for (int u = 0; u < 2; u++) chk_zero(u, "after_reset");

        for (int t = 0; t < 7; t++) run_job(jobs[t]);

        // spurious result while idle, then a start that clears the flag
        saved_wr = n_wr[0];
        inj_req[0]++;
        repeat (3) tick();
        chk("spurious_idle_err", 64'(err[0]), 64'd1);
        chk("spurious_idle_no_write", 64'(n_wr[0]), 64'(saved_wr));
        run_job(jobs[0]);
        // extra result after a completed job
        inj_req[0]++;
        repeat (3) tick();
        chk("extra_result_err", 64'(err[0]), 64'd1);
        chk("extra_result_no_write", 64'(n_wr[0]), 64'(N));

        // asynchronous reset in the middle of a job
        lat[0] = 3; withhold[0] = 99;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            tick();
            if (n_rd[0] == 5) hit = 1'b1;
        end
        chk("reached_issue5", 64'(hit), 64'd1);
        saved_done = n_done[0];
        #3 rst = 1'b1;
        #1;
        chk_zero(0, "midjob_reset");
        chk_zero(1, "midjob_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (8) tick();
        chk("no_done_after_abort", 64'(n_done[0]), 64'(saved_done));
        chk("idle_after_abort", 64'(busy[0]), 64'd0);
        run_job(jobs[0]);

        // randomized jobs checked against the scoreboard
        for (int r = 0; r < 6; r++) begin
            rj = '{int'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 99, 1'b0, 1'b0, 10, 1'b0};
            run_job(rj);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
